// File: rtl/out_merge_scheduler.sv
// Merges a varint byte stream and a raw byte stream into one output FIFO,
// one field-index burst at a time, in ascending index order.
module out_merge_scheduler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        varint_valid,
    input  logic [7:0]  varint_byte,
    input  logic [9:0]  varint_index,
    input  logic        varint_done,
    output logic        varint_accepted,
    input  logic        raw_valid,
    input  logic [7:0]  raw_byte,
    input  logic [9:0]  raw_index,
    input  logic        raw_done,
    output logic        raw_accepted,
    input  logic        out_fifo_full,
    output logic        out_fifo_push,
    output logic [7:0]  out_fifo_data,
    output logic        msg_done,
    output logic [15:0] byte_count,
    output logic        order_err,
    output logic [1:0]  dbg_state
);

    // dbg_state encoding: 0=ARB, 1=VAR, 2=RAW, 3=DONE
    typedef enum logic [1:0] {
        ARB  = 2'd0,
        VAR  = 2'd1,
        RAW  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [9:0]  r_cur_idx;
    logic        r_prior;
    logic [15:0] r_byte_count;
    logic        r_order_err;
    logic        r_msg_done;

    logic       w_var_hit;
    logic       w_raw_hit;
    logic       w_var_acc;
    logic       w_raw_acc;
    logic       w_go_var;
    logic       w_go_raw;
    logic [9:0] w_sel_idx;

    // Handshake: a head byte is consumed in the same cycle its *_accepted is
    // high (valid & matching burst index & FIFO not full); the source then
    // presents its next byte on the following cycle.
    assign w_var_hit = varint_valid && (varint_index == r_cur_idx);
    assign w_raw_hit = raw_valid && (raw_index == r_cur_idx);
    assign w_var_acc = (r_state == VAR) && w_var_hit && !out_fifo_full;
    assign w_raw_acc = (r_state == RAW) && w_raw_hit && !out_fifo_full;

    // A lone stream may only be scheduled once the other has finished the message.
    assign w_go_var  = varint_valid && (raw_valid ? (varint_index <= raw_index) : raw_done);
    assign w_go_raw  = raw_valid && (varint_valid ? (varint_index > raw_index) : varint_done);
    assign w_sel_idx = w_go_var ? varint_index : raw_index;

    assign varint_accepted = w_var_acc;
    assign raw_accepted    = w_raw_acc;
    assign out_fifo_push   = w_var_acc | w_raw_acc;
    assign out_fifo_data   = w_var_acc ? varint_byte : (w_raw_acc ? raw_byte : 8'h00);
    assign msg_done        = r_msg_done;
    assign byte_count      = r_byte_count;
    assign order_err       = r_order_err;
    assign dbg_state       = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ARB;
            r_cur_idx    <= 10'd0;
            r_prior      <= 1'b0;
            r_byte_count <= 16'd0;
            r_order_err  <= 1'b0;
            r_msg_done   <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;
            if (out_fifo_push) begin
                r_byte_count <= r_byte_count + 16'd1;
            end
            case (r_state)
                ARB: begin
                    if (w_go_var || w_go_raw) begin
                        r_state   <= w_go_var ? VAR : RAW;
                        r_cur_idx <= w_sel_idx;
                        r_prior   <= 1'b1;
                        // r_cur_idx still holds the previous burst's index here
                        if (r_prior && (w_sel_idx < r_cur_idx)) begin
                            r_order_err <= 1'b1;
                        end
                    end else if (!varint_valid && !raw_valid && varint_done && raw_done) begin
                        r_state    <= DONE;
                        r_msg_done <= 1'b1;
                    end
                end
                VAR: begin
                    if (!w_var_hit) begin
                        r_state <= ARB;
                    end
                end
                RAW: begin
                    if (!w_raw_hit) begin
                        r_state <= ARB;
                    end
                end
                DONE: begin
                    if (!varint_done && !raw_done) begin
                        r_state      <= ARB;
                        r_byte_count <= 16'd0;
                        r_order_err  <= 1'b0;
                        r_prior      <= 1'b0;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_out_merge_scheduler.sv
// Bench for out_merge_scheduler: directed messages plus randomized messages,
// checked against a queue-merge reference model.
module tb_out_merge_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        varint_valid = 1'b0;
    logic [7:0]  varint_byte = 8'h00;
    logic [9:0]  varint_index = 10'd0;
    logic        varint_done = 1'b0;
    logic        varint_accepted;
    logic        raw_valid = 1'b0;
    logic [7:0]  raw_byte = 8'h00;
    logic [9:0]  raw_index = 10'd0;
    logic        raw_done = 1'b0;
    logic        raw_accepted;
    logic        out_fifo_full = 1'b0;
    logic        out_fifo_push;
    logic [7:0]  out_fifo_data;
    logic        msg_done;
    logic [15:0] byte_count;
    logic        order_err;
    logic [1:0]  dbg_state;

    out_merge_scheduler dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .varint_valid    (varint_valid),
        .varint_byte     (varint_byte),
        .varint_index    (varint_index),
        .varint_done     (varint_done),
        .varint_accepted (varint_accepted),
        .raw_valid       (raw_valid),
        .raw_byte        (raw_byte),
        .raw_index       (raw_index),
        .raw_done        (raw_done),
        .raw_accepted    (raw_accepted),
        .out_fifo_full   (out_fifo_full),
        .out_fifo_push   (out_fifo_push),
        .out_fifo_data   (out_fifo_data),
        .msg_done        (msg_done),
        .byte_count      (byte_count),
        .order_err       (order_err),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "global timeout");
    end

    typedef struct packed {
        logic [9:0] idx;
        logic [7:0] b;
    } ent_t;

    ent_t       vq[$];
    ent_t       rq[$];
    ent_t       vd_q[$];
    ent_t       rd_q[$];
    logic [8:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         exp_err;
    int         exp_total;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference: repeatedly take the stream whose head index is lower (tie to
    // varint) and emit that index's whole run. In sequential mode the raw
    // stream is drained first, then varint.
    task automatic build_expected(input bit seq);
        ent_t       a[$];
        ent_t       b[$];
        bit         pick_v;
        bit         have_prev;
        logic [9:0] k;
        logic [9:0] prev;
        a = vq;
        b = rq;
        exp_q.delete();
        exp_err   = 1'b0;
        have_prev = 1'b0;
        prev      = 10'd0;
        while (a.size() != 0 || b.size() != 0) begin
            if (seq)
                pick_v = (b.size() == 0);
            else if (a.size() != 0 && b.size() != 0)
                pick_v = (a[0].idx <= b[0].idx);
            else
                pick_v = (a.size() != 0);
            k = pick_v ? a[0].idx : b[0].idx;
            if (have_prev && k < prev) exp_err = 1'b1;
            prev      = k;
            have_prev = 1'b1;
            if (pick_v) begin
                while (a.size() != 0 && a[0].idx == k) exp_q.push_back({1'b0, a.pop_front().b});
            end else begin
                while (b.size() != 0 && b[0].idx == k) exp_q.push_back({1'b1, b.pop_front().b});
            end
        end
        exp_total = exp_q.size();
    endtask

    task automatic gen_runs(input bit is_raw, input bit sorted);
        ent_t       q[$];
        ent_t       e;
        int         nr;
        int         len;
        logic [9:0] idx;
        logic [9:0] last;
        nr   = $urandom_range(0, 4);
        last = 10'($urandom_range(0, 40));
        for (int r = 0; r < nr; r++) begin
            if (sorted) begin
                idx = last + 10'($urandom_range(1, 8));
            end else begin
                idx = 10'($urandom_range(0, 1023));
                if (idx == last) idx = idx + 10'd1;
            end
            last = idx;
            len  = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                e.idx = idx;
                e.b   = 8'($urandom);
                q.push_back(e);
            end
        end
        if (is_raw) rq = q;
        else vq = q;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        varint_valid  = 1'b0;
        raw_valid     = 1'b0;
        varint_done   = 1'b0;
        raw_done      = 1'b0;
        out_fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // driver + scoreboard for one message
    task automatic run_msg(input bit seq, input int delay, input int full_lo, input int full_hi,
                           input bit rnd_full);
        int         cyc;
        bit         seen;
        bit         v_show;
        logic [8:0] e;
        logic [15:0] bc_at_done;
        logic        err_at_done;
        build_expected(seq);
        vd_q = vq;
        rd_q = rq;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            v_show        = seq ? (rd_q.size() == 0) : (cyc >= delay);
            varint_valid  = v_show && (vd_q.size() != 0);
            varint_index  = varint_valid ? vd_q[0].idx : 10'($urandom);
            varint_byte   = varint_valid ? vd_q[0].b : 8'($urandom);
            varint_done   = seq ? (rd_q.size() != 0 || vd_q.size() == 0)
                                : (cyc >= delay && vd_q.size() == 0);
            raw_valid     = (rd_q.size() != 0);
            raw_index     = raw_valid ? rd_q[0].idx : 10'($urandom);
            raw_byte      = raw_valid ? rd_q[0].b : 8'($urandom);
            raw_done      = (rd_q.size() == 0);
            out_fifo_full = (cyc >= full_lo && cyc <= full_hi) || (rnd_full && $urandom_range(0, 3) == 0);
            #1;
            check_eq("push_vs_accept", out_fifo_push, varint_accepted | raw_accepted);
            check_eq("dual_accept", varint_accepted & raw_accepted, 0);
            if (out_fifo_full) check_eq("push_while_full", out_fifo_push, 0);
            if (out_fifo_push) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_push", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("push_byte", {raw_accepted, out_fifo_data}, e);
                end
                if (raw_accepted && rd_q.size() != 0) rd_q.pop_front();
                if (varint_accepted && vd_q.size() != 0) vd_q.pop_front();
            end else begin
                check_eq("idle_data", out_fifo_data, 0);
            end
            if (msg_done) seen = 1'b1;
            cyc++;
        end
        if (!seen) begin
            check_eq("msg_done_timeout", 0, 1);
            do_reset();
            return;
        end
        check_eq("exp_drained", exp_q.size(), 0);
        check_eq("byte_count", byte_count, exp_total);
        check_eq("order_err", order_err, exp_err);
        bc_at_done  = 16'(exp_total);
        err_at_done = exp_err;
        @(negedge clk);
        out_fifo_full = 1'b0;
        #1;
        check_eq("msg_done_pulse", msg_done, 0);
        check_eq("done_bc_hold", byte_count, bc_at_done);
        check_eq("done_err_hold", order_err, err_at_done);
        check_eq("done_state", dbg_state, 3);
        @(negedge clk);
        varint_done = 1'b0;
        raw_done    = 1'b0;
        #1;
        check_eq("done_wait_state", dbg_state, 3);
        @(negedge clk);
        #1;
        check_eq("clear_bc", byte_count, 0);
        check_eq("clear_err", order_err, 0);
        check_eq("arb_state", dbg_state, 0);
    endtask

    task automatic fill(input bit is_raw, input logic [9:0] idx, input int n, input logic [7:0] base);
        ent_t e;
        for (int j = 0; j < n; j++) begin
            e.idx = idx;
            e.b   = base + 8'(j);
            if (is_raw) rq.push_back(e);
            else vq.push_back(e);
        end
    endtask

    initial begin
        #1;
        check_eq("rst_bc", byte_count, 0);
        check_eq("rst_err", order_err, 0);
        check_eq("rst_msg_done", msg_done, 0);
        check_eq("rst_push", out_fifo_push, 0);
        check_eq("rst_state", dbg_state, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // two varint bytes at idx 3, four raw bytes at idx 5
        vq.delete(); rq.delete();
        fill(1'b0, 10'd3, 1, 8'h96);
        fill(1'b0, 10'd3, 1, 8'h01);
        fill(1'b1, 10'd5, 4, 8'hA0);
        run_msg(1'b0, 0, 1, 0, 1'b0);

        // equal index on both streams
        vq.delete(); rq.delete();
        fill(1'b0, 10'd7, 2, 8'h10);
        fill(1'b1, 10'd7, 3, 8'h20);
        run_msg(1'b0, 0, 1, 0, 1'b0);

        // raw waits for varint source that has not finished
        vq.delete(); rq.delete();
        fill(1'b1, 10'd2, 3, 8'h30);
        fill(1'b0, 10'd1, 2, 8'h40);
        run_msg(1'b0, 10, 1, 0, 1'b0);

        // FIFO full for five cycles inside a raw burst
        vq.delete(); rq.delete();
        fill(1'b0, 10'd1, 1, 8'h50);
        fill(1'b1, 10'd5, 6, 8'h60);
        run_msg(1'b0, 0, 4, 8, 1'b0);

        // raw idx 9 first, then varint idx 4: out of order
        vq.delete(); rq.delete();
        fill(1'b1, 10'd9, 2, 8'h70);
        fill(1'b0, 10'd4, 1, 8'h80);
        run_msg(1'b1, 0, 1, 0, 1'b0);

        // reset in the middle of a burst
        @(negedge clk);
        varint_valid = 1'b1; varint_index = 10'd3; varint_byte = 8'hAA; varint_done = 1'b0;
        raw_valid = 1'b1; raw_index = 10'd5; raw_byte = 8'hBB; raw_done = 1'b0;
        out_fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("pre_reset_push", out_fifo_push, 1);
        check_eq("pre_reset_data", out_fifo_data, 8'hAA);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_push", out_fifo_push, 0);
        check_eq("rst_mid_vacc", varint_accepted, 0);
        check_eq("rst_mid_racc", raw_accepted, 0);
        check_eq("rst_mid_data", out_fifo_data, 0);
        check_eq("rst_mid_bc", byte_count, 0);
        check_eq("rst_mid_state", dbg_state, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_push", out_fifo_push, 0);
        check_eq("post_rst_state", dbg_state, 0);
        #1;
        varint_valid = 1'b0;
        raw_valid    = 1'b0;
        @(negedge clk);

        for (int m = 0; m < 30; m++) begin
            bit srt;
            srt = ($urandom_range(0, 2) != 0);
            gen_runs(1'b0, srt);
            gen_runs(1'b1, srt);
            run_msg($urandom_range(0, 4) == 0, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0,
                    1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/out_merge_scheduler.md
OUT_MERGE_SCHEDULER -- requirements
Module: out_merge_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below in order.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 varint_valid  input  1  head byte of the varint-encoded stream is present.
REQ-005 varint_byte  input  8  head byte of the varint stream.
REQ-006 varint_index  input  10  field index of the varint head byte.
REQ-007 varint_done  input  1  level; varint source has no further bytes for the current message.
REQ-008 varint_accepted  output  1  head varint byte consumed this cycle.
REQ-009 raw_valid, raw_byte[7:0], raw_index[9:0], raw_done  inputs; same meaning as REQ-004..007 for the raw-data stream.
REQ-010 raw_accepted  output  1  head raw byte consumed this cycle.
REQ-011 out_fifo_full  input  1  output FIFO cannot accept a byte.
REQ-012 out_fifo_push  output  1  write strobe to output FIFO.
REQ-013 out_fifo_data  output  8  byte written to output FIFO.
REQ-014 msg_done  output  1  one-cycle pulse: message fully merged.
REQ-015 byte_count  output  16  bytes pushed in current message.
REQ-016 order_err  output  1  sticky: a burst index was lower than the previous burst index.

Function
REQ-017 The block SHALL merge both streams into the output FIFO in ascending field-index order, emitting each index's bytes as an uninterrupted burst.
REQ-018 States SHALL be ARB, VAR, RAW, DONE.
REQ-019 ARB, both valid: go VAR if varint_index <= raw_index, else RAW (tie favours varint).
REQ-020 ARB, only varint_valid: go VAR only if raw_done=1; otherwise stay in ARB.
REQ-021 ARB, only raw_valid: go RAW only if varint_done=1; otherwise stay in ARB.
REQ-022 ARB, neither valid, varint_done=1 and raw_done=1: go DONE.
REQ-023 Leaving ARB for VAR/RAW SHALL latch the selected index into cur_idx.
REQ-024 In VAR: varint_accepted = varint_valid & (varint_index==cur_idx) & !out_fifo_full, combinational.
REQ-025 In RAW: raw_accepted is defined as in REQ-024, using raw signals.
REQ-026 out_fifo_push SHALL equal varint_accepted | raw_accepted (zero latency); the two SHALL never be high together.
REQ-027 out_fifo_data SHALL be the byte of the accepted stream, and 8'h00 when no push.
REQ-028 VAR/RAW SHALL return to ARB on the first cycle the active stream's valid is low or its index differs from cur_idx; no byte is accepted that cycle.
REQ-029 While out_fifo_full=1, the state SHALL hold with no accept.
REQ-030 On entry to VAR/RAW, if a prior burst exists in the message and the new index < the previous cur_idx, order_err SHALL set; the burst still proceeds.
REQ-031 Equal index across consecutive bursts (gap in valid, or varint then raw of the same index) SHALL NOT flag order_err.
REQ-032 Index compare SHALL be 10-bit unsigned; no wrap-around semantics.
REQ-033 byte_count SHALL increment by 1 per push and wrap from 16'hFFFF to 0.
REQ-034 msg_done SHALL pulse high for exactly the first DONE cycle.
REQ-035 DONE SHALL go to ARB only when varint_done=0 and raw_done=0; the transition SHALL clear byte_count, order_err and prior-burst status.
REQ-036 byte_count and order_err SHALL hold their values throughout DONE.

Reset
REQ-037 On reset_n=0, asynchronously: state=ARB, cur_idx=0, prior-burst status cleared, byte_count=0, order_err=0, msg_done=0.
REQ-038 During reset, accepted and push outputs SHALL be 0; a burst interrupted by reset is abandoned, with no partial re-emit.

Verification
REQ-039 Varint idx 3 ×2 bytes (0x96,0x01), raw idx 5 ×4 bytes -> FIFO gets varint bytes, then 4 raw bytes; byte_count=6.
REQ-040 Both valid at idx 7 -> varint burst first, then raw burst; order_err=0.
REQ-041 raw_valid idx 2, varint_done=0 for 10 cycles -> no push; varint idx 1 arrives -> varint emitted first.
REQ-042 out_fifo_full held 5 cycles mid-burst -> no accept or push; byte order is preserved after release.
REQ-043 Raw idx 9 emitted; then varint idx 4 with raw_done=1 -> order_err=1, emitted anyway; both done -> msg_done one cycle, byte_count held; done released -> counters=0.
REQ-044 reset_n low mid-burst -> all outputs 0 immediately; after release, state=ARB with no push until arbitration.
